// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Controller for the single-port unified SRAM. It is shared by the DLX
// instruction-fetch stage and the MEM-stage data port.
//
// Arbitration
//   Both requesters are arbitrated in IDLE. The data port normally wins,
//   because it belongs to the older instruction. A starvation guard hands the
//   next grant to fetch after two back-to-back data grants that were made
//   while fetch was waiting.
//
// Read cycles
//   mem_cs/mem_oe are held for WAIT_CYCLES cycles. mem_dout is captured on the
//   last cycle of that window.
//
// Write cycles
//   mem_cs/mem_we are held for WE_CYCLES cycles. mem_din and mem_addr are
//   stable for the whole window.
//
// Loads
//   Byte and halfword loads are extracted from big-endian lanes and
//   right-justified. They are then zero- or sign-extended.
//
// Stores
//   The SRAM has no byte enables. Byte and halfword stores are therefore done
//   as read-modify-write: RD, then MRG, then WR.
//
// Ports
//   clk, reset_n        : rising-edge clock, async active-low reset
//   i_req/i_addr        : fetch request and byte address (bits [1:0] unused)
//   i_ack/i_rdata       : fetch completion pulse and fetched word
//   d_req/d_we/d_size   : data request, store flag, size (00 B, 01 H, 1x W)
//   d_signed            : sign-extend sub-word loads
//   d_addr/d_wdata      : data byte address and right-justified store data
//   d_ack/d_err/d_rdata : data completion pulse, misalign flag, load result
//   mem_cs/oe/we        : SRAM controls
//   mem_addr/mem_din    : SRAM word address and write data
//   mem_dout            : SRAM read data
//   busy                : controller not in IDLE
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int WE_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        DONE
    } state_t;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_guard;

    // Transaction latched at grant
    logic             r_is_data;
    logic             r_we;
    logic             r_signed;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic [31:0]      r_wdata;

    // Datapath registers
    logic [31:0]      r_rword;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_din;
    logic [31:0]      r_i_rdata;
    logic [31:0]      r_d_rdata;
    logic             r_d_err;

    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_misalign;
    logic             w_word_store;
    logic             w_cnt_zero;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;
    logic             w_unused;

    // Fetch addresses are always word aligned; the low bits carry no meaning.
    assign w_unused = &{1'b0, i_addr[1:0]};

    // Arbitration. Data wins unless fetch has been passed over twice in a row.
    // Size 11 is handled as a word, so testing d_size[1] covers both encodings.
    always_comb begin
        w_grant_d    = d_req && !(i_req && (r_guard == 2'd2));
        w_grant_i    = i_req && !w_grant_d;
        w_misalign   = ((d_size == 2'b01) && d_addr[0]) ||
                       (d_size[1] && (d_addr[1:0] != 2'b00));
        w_word_store = d_we && d_size[1];
        w_cnt_zero   = (r_cnt == '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A store only reaches RD when it is sub-word,
    // because word stores go straight to WR.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    if (w_misalign) begin
                        w_next = DONE;
                    end else if (w_word_store) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end else if (w_grant_i) begin
                    w_next = RD;
                end
            end
            RD: begin
                if (w_cnt_zero) begin
                    w_next = r_we ? MRG : DONE;
                end
            end
            MRG: begin
                w_next = WR;
            end
            WR: begin
                if (w_cnt_zero) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Wait counter and starvation guard.
    // The counter is loaded on entry to RD/WR and runs down to zero.
    // The guard counts data grants made while fetch was waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_guard <= 2'd0;
        end else begin
            if ((w_next == RD) && (r_state != RD)) begin
                r_cnt <= RD_LOAD;
            end else if ((w_next == WR) && (r_state != WR)) begin
                r_cnt <= WR_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (r_state == IDLE) begin
                if (w_grant_i) begin
                    r_guard <= 2'd0;
                end else if (w_grant_d) begin
                    if (i_req) begin
                        r_guard <= r_guard + 2'd1;
                    end else begin
                        r_guard <= 2'd0;
                    end
                end
            end
        end
    end

    // Latch the winner's request at grant. Requester inputs are not looked
    // at again until the next IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_data <= 1'b0;
            r_we      <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= 2'b00;
            r_wdata   <= '0;
        end else if ((r_state == IDLE) && (w_grant_d || w_grant_i)) begin
            r_is_data <= w_grant_d;
            if (w_grant_d) begin
                r_we     <= d_we;
                r_signed <= d_signed;
                r_size   <= d_size;
                r_off    <= d_addr[1:0];
                r_wdata  <= d_wdata;
            end else begin
                r_we     <= 1'b0;
                r_signed <= 1'b0;
                r_size   <= 2'b10;
                r_off    <= 2'b00;
                r_wdata  <= '0;
            end
        end
    end

    // Big-endian lane extraction from the live SRAM data. The result is
    // used on the last RD cycle, when mem_dout is captured.
    always_comb begin
        w_byte = mem_dout[31:24];
        case (r_off)
            2'd0: w_byte = mem_dout[31:24];
            2'd1: w_byte = mem_dout[23:16];
            2'd2: w_byte = mem_dout[15:8];
            2'd3: w_byte = mem_dout[7:0];
        endcase
        w_half = r_off[1] ? mem_dout[15:0] : mem_dout[31:16];
        if (r_size[1]) begin
            w_load = mem_dout;
        end else if (r_size[0]) begin
            w_load = {{16{r_signed & w_half[15]}}, w_half};
        end else begin
            w_load = {{24{r_signed & w_byte[7]}}, w_byte};
        end
    end

    // Read-modify-write merge. The addressed lane of the captured word is
    // replaced by the low byte/half of the store data.
    always_comb begin
        w_merged = r_rword;
        if (r_size[0]) begin
            if (r_off[1]) begin
                w_merged[15:0] = r_wdata[15:0];
            end else begin
                w_merged[31:16] = r_wdata[15:0];
            end
        end else begin
            case (r_off)
                2'd0: w_merged[31:24] = r_wdata[7:0];
                2'd1: w_merged[23:16] = r_wdata[7:0];
                2'd2: w_merged[15:8]  = r_wdata[7:0];
                2'd3: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end
    end

    // SRAM address/data registers and the results held for each port.
    // mem_addr/mem_din are zero outside an access. They hold steady across
    // RD, MRG and WR. Results change only on an ack to their own port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rword    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if ((w_next == RD) || (w_next == WR)) begin
                    r_mem_addr <= w_grant_d ? {d_addr[31:2], 2'b00}
                                            : {i_addr[31:2], 2'b00};
                end else begin
                    r_mem_addr <= '0;
                end
            end else if (w_next == DONE) begin
                r_mem_addr <= '0;
            end

            if ((r_state == IDLE) && (w_next == WR)) begin
                r_mem_din <= d_wdata;
            end else if (r_state == MRG) begin
                r_mem_din <= w_merged;
            end else if (w_next == DONE) begin
                r_mem_din <= '0;
            end

            if ((r_state == RD) && w_cnt_zero) begin
                r_rword <= mem_dout;
            end

            if ((r_state == IDLE) && w_grant_d && w_misalign) begin
                r_d_err   <= 1'b1;
                r_d_rdata <= '0;
            end else if ((w_next == DONE) && (r_state != IDLE)) begin
                if (r_is_data) begin
                    r_d_err   <= 1'b0;
                    r_d_rdata <= (r_state == RD) ? w_load : '0;
                end else begin
                    r_i_rdata <= mem_dout;
                end
            end
        end
    end

    // Outputs. Controls decode directly from the state register, so a reset
    // drops mem_we at once.
    always_comb begin
        busy     = (r_state != IDLE);
        i_ack    = (r_state == DONE) && !r_is_data;
        d_ack    = (r_state == DONE) && r_is_data;
        mem_cs   = (r_state == RD) || (r_state == WR);
        mem_oe   = (r_state == RD);
        mem_we   = (r_state == WR);
        mem_addr = r_mem_addr;
        mem_din  = r_mem_din;
        i_rdata  = r_i_rdata;
        d_rdata  = r_d_rdata;
        d_err    = r_d_err;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter, with WAIT_CYCLES=1 and WE_CYCLES=3.
// A small behavioural SRAM answers reads and takes writes. Negedge monitors
// count control and ack activity for the scenario tasks to compare against.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int WAIT_CYCLES = 1;
    localparam int WE_CYCLES   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    int          cycles;
    logic [31:0] rdata;
    logic        err;

    sram_arbiter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .WE_CYCLES   (WE_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_size   (d_size),
        .d_signed (d_signed),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_err    (d_err),
        .d_rdata  (d_rdata),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM (64 words). Reads return a marker value whenever the
    // output enable is off.
    logic [31:0] sram [0:63];
    assign mem_dout = (mem_cs && mem_oe) ? sram[mem_addr[7:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (mem_cs && mem_we) sram[mem_addr[7:2]] = mem_din;
    end

    // Activity monitors, sampled mid-cycle
    int          csCount, oeCount, weCount, iAckCount, dAckCount;
    logic [31:0] csAddr, weDin;
    logic        dinUnstable, oeWithWe;
    always @(negedge clk) begin
        if (mem_cs) begin csCount++; csAddr = mem_addr; end
        if (mem_oe) oeCount++;
        if (mem_we) begin
            if (weCount > 0 && mem_din !== weDin) dinUnstable = 1'b1;
            if (mem_oe) oeWithWe = 1'b1;
            weDin = mem_din;
            weCount++;
        end
        if (i_ack) iAckCount++;
        if (d_ack) dAckCount++;
    end

    task automatic clearMon();
        csCount = 0; oeCount = 0; weCount = 0; iAckCount = 0; dAckCount = 0;
        csAddr = '0; weDin = '0; dinUnstable = 1'b0; oeWithWe = 1'b0;
    endtask

    // Issue a fetch in the current IDLE cycle. Cycles are counted from that
    // cycle to the ack cycle. The request is dropped in the cycle after ack.
    task automatic runFetch(input logic [31:0] addr, output int cyc, output logic [31:0] rd);
        i_addr = addr; i_req = 1'b1; cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!i_ack && cyc < 40);
        rd = i_rdata;
        @(posedge clk); #1;
        i_req = 1'b0; i_addr = 32'hFFFF_FFFF;
    endtask

    // Issue a data access the same way as runFetch.
    task automatic runData(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int cyc, output logic [31:0] rd, output logic er);
        d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
        d_req = 1'b1; cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!d_ack && cyc < 40);
        rd = d_rdata; er = d_err;
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'b10; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
        clearMon();
        #2;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if ({mem_cs, mem_oe, mem_we} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {mem_cs, mem_oe, mem_we}); end
        compared++; if ({i_ack, d_ack, d_err} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_ack: got %b expected 000", {i_ack, d_ack, d_err}); end
        compared++; if ({i_rdata, d_rdata} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
        compared++; if ({mem_addr, mem_din} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_din}); end
        #20;
        reset_n = 1'b1;
        @(posedge clk); #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idle_after_release: busy %b expected 0", busy); end
    endtask

    task automatic test_fetch();
        sram[0] = 32'h2001_AAAA;
        sram[1] = 32'h0BAD_F00D;
        clearMon();
        runFetch(32'h0, cycles, rdata);
        compared++; if (cycles !== 2) begin mismatched++; $display("[TB] FAIL fetch_latency: got %0d expected 2", cycles); end
        compared++; if (rdata !== 32'h2001_AAAA) begin mismatched++; $display("[TB] FAIL fetch_rdata: got %h expected 2001aaaa", rdata); end
        compared++; if (csCount !== 1 || oeCount !== 1 || weCount !== 0) begin mismatched++; $display("[TB] FAIL fetch_ctrl_window: cs %0d oe %0d we %0d expected 1 1 0", csCount, oeCount, weCount); end
        compared++; if (i_ack !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_ack_pulse: ack %b busy %b expected 0 0", i_ack, busy); end
        compared++; if (i_rdata !== 32'h2001_AAAA) begin mismatched++; $display("[TB] FAIL fetch_rdata_held: got %h expected 2001aaaa", i_rdata); end
        clearMon();
        runFetch(32'h7, cycles, rdata);
        compared++; if (rdata !== 32'h0BAD_F00D || csAddr !== 32'h4) begin mismatched++; $display("[TB] FAIL fetch_low_bits_ignored: rdata %h addr %h expected 0badf00d 4", rdata, csAddr); end
        compared++; if (mem_addr !== 32'h0 || dAckCount !== 0) begin mismatched++; $display("[TB] FAIL fetch_idle_bus: addr %h dacks %0d expected 0 0", mem_addr, dAckCount); end
    endtask

    task automatic test_loads();
        sram[32] = 32'hF0F0_F0F0;
        clearMon();
        runData(1'b0, 2'b00, 1'b0, 32'h81, 32'h0, cycles, rdata, err);
        compared++; if (cycles !== 2) begin mismatched++; $display("[TB] FAIL load_latency: got %0d expected 2", cycles); end
        compared++; if (rdata !== 32'h0000_00F0 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL load_byte_unsigned: got %h err %b expected 000000f0 0", rdata, err); end
        compared++; if (csAddr !== 32'h80) begin mismatched++; $display("[TB] FAIL load_word_addr: got %h expected 80", csAddr); end
        runData(1'b0, 2'b00, 1'b1, 32'h81, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'hFFFF_FFF0) begin mismatched++; $display("[TB] FAIL load_byte_signed: got %h expected fffffff0", rdata); end
        sram[32] = 32'h1122_3344;
        runData(1'b0, 2'b00, 1'b1, 32'h80, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'h0000_0011) begin mismatched++; $display("[TB] FAIL load_byte_off0: got %h expected 00000011", rdata); end
        runData(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'h0000_1122) begin mismatched++; $display("[TB] FAIL load_half_off0: got %h expected 00001122", rdata); end
        runData(1'b0, 2'b01, 1'b0, 32'h82, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'h0000_3344) begin mismatched++; $display("[TB] FAIL load_half_off2: got %h expected 00003344", rdata); end
    endtask

    task automatic test_subword_store();
        sram[32] = 32'h1122_3344;
        clearMon();
        runData(1'b1, 2'b00, 1'b0, 32'h82, 32'h1234_56AB, cycles, rdata, err);
        compared++; if (cycles !== WAIT_CYCLES + WE_CYCLES + 2) begin mismatched++; $display("[TB] FAIL sb_latency: got %0d expected %0d", cycles, WAIT_CYCLES + WE_CYCLES + 2); end
        compared++; if (oeCount !== 1 || weCount !== 3 || csCount !== 4) begin mismatched++; $display("[TB] FAIL sb_windows: oe %0d we %0d cs %0d expected 1 3 4", oeCount, weCount, csCount); end
        compared++; if (weDin !== 32'h1122_AB44 || dinUnstable !== 1'b0 || oeWithWe !== 1'b0) begin mismatched++; $display("[TB] FAIL sb_din: got %h unstable %b oe %b expected 1122ab44 0 0", weDin, dinUnstable, oeWithWe); end
        compared++; if (sram[32] !== 32'h1122_AB44 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL sb_result: got %h err %b expected 1122ab44 0", sram[32], err); end
        runData(1'b0, 2'b01, 1'b1, 32'h82, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'hFFFF_AB44) begin mismatched++; $display("[TB] FAIL sb_half_signed_readback: got %h expected ffffab44", rdata); end
        runData(1'b1, 2'b01, 1'b0, 32'h80, 32'h0000_BEEF, cycles, rdata, err);
        compared++; if (sram[32] !== 32'hBEEF_AB44 || cycles !== 6) begin mismatched++; $display("[TB] FAIL sh_merge: got %h cycles %0d expected beefab44 6", sram[32], cycles); end
    endtask

    task automatic test_word_store();
        sram[33] = 32'h0;
        clearMon();
        runData(1'b1, 2'b10, 1'b0, 32'h84, 32'hCAFE_BABE, cycles, rdata, err);
        compared++; if (cycles !== WE_CYCLES + 1) begin mismatched++; $display("[TB] FAIL sw_latency: got %0d expected %0d", cycles, WE_CYCLES + 1); end
        compared++; if (oeCount !== 0 || weCount !== 3 || sram[33] !== 32'hCAFE_BABE) begin mismatched++; $display("[TB] FAIL sw_write: oe %0d we %0d word %h expected 0 3 cafebabe", oeCount, weCount, sram[33]); end
        runData(1'b0, 2'b11, 1'b1, 32'h84, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'hCAFE_BABE) begin mismatched++; $display("[TB] FAIL sw_size11_readback: got %h expected cafebabe", rdata); end
    endtask

    task automatic test_misaligned();
        clearMon();
        runData(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, cycles, rdata, err);
        compared++; if (cycles !== 1) begin mismatched++; $display("[TB] FAIL mis_latency: got %0d expected 1", cycles); end
        compared++; if (err !== 1'b1 || rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL mis_word_err: err %b rdata %h expected 1 0", err, rdata); end
        compared++; if (csCount !== 0) begin mismatched++; $display("[TB] FAIL mis_no_cs: got %0d expected 0", csCount); end
        runData(1'b1, 2'b01, 1'b0, 32'h83, 32'h1111, cycles, rdata, err);
        compared++; if (err !== 1'b1 || weCount !== 0 || cycles !== 1) begin mismatched++; $display("[TB] FAIL mis_half_store: err %b we %0d cycles %0d expected 1 0 1", err, weCount, cycles); end
        compared++; if (d_err !== 1'b1) begin mismatched++; $display("[TB] FAIL mis_err_held: got %b expected 1", d_err); end
        runData(1'b0, 2'b00, 1'b0, 32'h83, 32'h0, cycles, rdata, err);
        compared++; if (err !== 1'b0 || rdata !== 32'h0000_0044) begin mismatched++; $display("[TB] FAIL mis_byte_ok: err %b rdata %h expected 0 00000044", err, rdata); end
    endtask

    task automatic test_contention();
        int         cyc;
        int         n;
        logic [5:0] seq;
        logic       overlap;
        sram[0]  = 32'h2001_AAAA;
        sram[32] = 32'h0BAD_CAFE;
        runFetch(32'h0, cycles, rdata);
        clearMon();
        i_addr = 32'h0; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h80;
        i_req = 1'b1; d_req = 1'b1;
        cyc = 0; n = 0; seq = '0; overlap = 1'b0;
        while (n < 6 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (i_ack && d_ack) overlap = 1'b1;
            if (d_ack) begin seq = {seq[4:0], 1'b1}; n++; end
            else if (i_ack) begin seq = {seq[4:0], 1'b0}; n++; end
        end
        compared++; if (n !== 6 || cyc !== 17) begin mismatched++; $display("[TB] FAIL arb_count: acks %0d last cycle %0d expected 6 17", n, cyc); end
        compared++; if (seq !== 6'b110110) begin mismatched++; $display("[TB] FAIL arb_order: got %b expected 110110 (1=D)", seq); end
        compared++; if (overlap !== 1'b0) begin mismatched++; $display("[TB] FAIL arb_overlap: got %b expected 0", overlap); end
        compared++; if (i_rdata !== 32'h2001_AAAA || d_rdata !== 32'h0BAD_CAFE) begin mismatched++; $display("[TB] FAIL arb_data: i %h d %h expected 2001aaaa 0badcafe", i_rdata, d_rdata); end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        compared++; if (iAckCount !== 2 || dAckCount !== 4) begin mismatched++; $display("[TB] FAIL arb_ack_pulses: i %0d d %0d expected 2 4", iAckCount, dAckCount); end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        d_we = 1'b1; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h88; d_wdata = 32'h55AA_55AA;
        d_req = 1'b1; cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!mem_we && cyc < 20);
        compared++; if (mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_wr_reached: mem_we %b expected 1", mem_we); end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        compared++; if ({mem_cs, mem_oe, mem_we} !== 3'b000) begin mismatched++; $display("[TB] FAIL rst_async_ctrl: got %b expected 000", {mem_cs, mem_oe, mem_we}); end
        compared++; if ({busy, i_ack, d_ack, d_err} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_async_flags: got %b expected 0000", {busy, i_ack, d_ack, d_err}); end
        compared++; if ({mem_addr, mem_din, i_rdata, d_rdata} !== 128'h0) begin mismatched++; $display("[TB] FAIL rst_async_data: got %h expected 0", {mem_addr, mem_din, i_rdata, d_rdata}); end
        d_req = 1'b0; d_we = 1'b0;
        clearMon();
        #20;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        compared++; if (iAckCount !== 0 || dAckCount !== 0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_no_stray_ack: i %0d d %0d busy %b expected 0 0 0", iAckCount, dAckCount, busy); end
        sram[32] = 32'h1122_3344;
        runData(1'b0, 2'b00, 1'b0, 32'h83, 32'h0, cycles, rdata, err);
        compared++; if (rdata !== 32'h0000_0044 || cycles !== 2) begin mismatched++; $display("[TB] FAIL rst_recover: rdata %h cycles %0d expected 00000044 2", rdata, cycles); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_subword_store();
        test_word_store();
        test_misaligned();
        test_contention();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
